// File: rtl/des_pkg.sv
// Shared types and constants for the DES block-chaining front end.
package des_pkg;

    localparam int unsigned DES_BLK_W = 64;
    localparam int unsigned DES_KEY_W = 64;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_OUT    = 2'd3
    } state_e;

    // Plain constant views of the state encoding for legacy-style FSM code
    localparam logic [1:0] ST_IDLE   = S_IDLE;
    localparam logic [1:0] ST_LAUNCH = S_LAUNCH;
    localparam logic [1:0] ST_WAIT   = S_WAIT;
    localparam logic [1:0] ST_OUT    = S_OUT;

    localparam logic MODE_ENC  = 1'b0;
    localparam logic MODE_DEC  = 1'b1;
    localparam logic CHAIN_ECB = 1'b0;
    localparam logic CHAIN_CBC = 1'b1;

endpackage

// File: rtl/des_cbc_ctrl.sv
// ECB/CBC chaining front end feeding a DES core, one block in flight at a time.
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter int unsigned START_HOLD     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_cbc,
    input  logic                 cfg_decrypt,
    input  logic [DES_KEY_W-1:0] cfg_key,
    input  logic [DES_BLK_W-1:0] cfg_iv,
    input  logic                 iv_load,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DES_BLK_W-1:0] s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DES_BLK_W-1:0] m_data,
    output logic                 m_last,
    output logic [DES_BLK_W-1:0] core_din,
    output logic                 core_start,
    output logic                 core_mode,
    output logic [DES_KEY_W-1:0] core_key,
    input  logic [DES_BLK_W-1:0] core_dout,
    input  logic                 core_valid,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int unsigned HOLD_W = $clog2(START_HOLD + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]           state;
    logic [1:0]           state_d;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [DES_BLK_W-1:0] chain;
    logic [DES_BLK_W-1:0] chain_in;
    logic [DES_BLK_W-1:0] blk_q;
    logic                 cbc_q;
    logic                 dec_q;
    logic                 last_q;

    logic accept;
    logic iv_take;
    logic hold_done;
    logic core_hit;
    logic timeout;
    logic out_done;

    // Event decode and next-state logic
    always_comb begin
        state_d   = state;
        accept    = s_valid & s_ready;
        iv_take   = iv_load & (state == ST_IDLE);
        hold_done = (state == ST_LAUNCH) && (hold_cnt == HOLD_W'(START_HOLD - 1));
        core_hit  = (state == ST_WAIT) && core_valid;
        timeout   = (state == ST_WAIT) && !core_valid
                    && (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));
        out_done  = (state == ST_OUT) && m_valid && m_ready;
        // A simultaneous iv_load wins over the old chain value for this block
        chain_in  = iv_take ? cfg_iv : chain;

        case (state)
            ST_IDLE:   if (accept)    state_d = ST_LAUNCH;
            ST_LAUNCH: if (hold_done) state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_hit)     state_d = ST_OUT;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_OUT:    if (out_done)  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Datapath, core interface and output stream registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
            core_din    <= '0;
            core_start  <= 1'b0;
            core_mode   <= 1'b0;
            core_key    <= '0;
            err_timeout <= 1'b0;
            chain       <= '0;
            blk_q       <= '0;
            cbc_q       <= 1'b0;
            dec_q       <= 1'b0;
            last_q      <= 1'b0;
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            s_ready <= (state_d == ST_IDLE);
            busy    <= (state_d != ST_IDLE);

            if (iv_take) begin
                chain       <= cfg_iv;
                err_timeout <= 1'b0;
            end

            if (accept) begin
                cbc_q      <= cfg_cbc;
                dec_q      <= cfg_decrypt;
                last_q     <= s_last;
                blk_q      <= s_data;
                core_key   <= cfg_key;
                core_mode  <= cfg_decrypt;
                core_din   <= (cfg_cbc == CHAIN_CBC && cfg_decrypt == MODE_ENC)
                              ? (s_data ^ chain_in) : s_data;
                core_start <= 1'b1;
                hold_cnt   <= '0;
                tmo_cnt    <= '0;
            end

            if (state == ST_LAUNCH) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
                if (hold_done) core_start <= 1'b0;
            end

            // Timeout counter runs from the core_start rise and saturates
            if ((state == ST_LAUNCH || state == ST_WAIT)
                && tmo_cnt != TMO_W'(TIMEOUT_CYCLES)) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (core_hit) begin
                m_valid <= 1'b1;
                m_last  <= last_q;
                if (cbc_q == CHAIN_CBC && dec_q == MODE_DEC) begin
                    m_data <= core_dout ^ chain;
                    chain  <= blk_q;
                end else begin
                    m_data <= core_dout;
                    if (cbc_q == CHAIN_CBC) chain <= core_dout;
                end
            end

            if (timeout) begin
                err_timeout <= 1'b1;
                chain       <= cfg_iv;
            end

            if (out_done) begin
                m_valid <= 1'b0;
                if (last_q && cbc_q == CHAIN_CBC) chain <= cfg_iv;
            end
        end
    end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Directed scoreboard bench for des_cbc_ctrl with a behavioural DES core stand-in.
module tb_des_cbc_ctrl;
    import des_pkg::*;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_cbc, cfg_decrypt, iv_load;
    logic [63:0] cfg_key, cfg_iv;
    logic        s_valid, s_ready, s_last;
    logic [63:0] s_data;
    logic        m_valid, m_ready, m_last;
    logic [63:0] m_data;
    logic [63:0] core_din, core_key, core_dout;
    logic        core_start, core_mode, core_valid;
    logic        busy, err_timeout;

    always #5 clk = ~clk;

    des_cbc_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_cbc(cfg_cbc), .cfg_decrypt(cfg_decrypt), .cfg_key(cfg_key),
        .cfg_iv(cfg_iv), .iv_load(iv_load),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_din(core_din), .core_start(core_start), .core_mode(core_mode),
        .core_key(core_key), .core_dout(core_dout), .core_valid(core_valid),
        .busy(busy), .err_timeout(err_timeout)
    );

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_data_q[$];
    logic        exp_last_q[$];
    logic [63:0] mchain = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Stand-in for the DES core: known test vector plus an invertible fallback
    function automatic logic [63:0] core_fn(input logic [63:0] din, input logic dec,
                                            input logic [63:0] key);
        if (key == KEY && !dec && din == PT) return CT;
        if (key == KEY && dec && din == CT) return PT;
        return din ^ {key[31:0], key[63:32]};
    endfunction

    logic        core_en = 1'b1;
    int          core_lat = 4;
    logic        prev_start;
    int          pend;
    logic [63:0] pend_dout;
    int          hi_cnt;
    int          hi_len = 0;
    logic [63:0] cap_din = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_valid <= 1'b0;
            core_dout  <= '0;
            prev_start <= 1'b0;
            pend       <= 0;
            hi_cnt     <= 0;
        end else begin
            core_valid <= 1'b0;
            prev_start <= core_start;
            if (core_start && !prev_start) begin
                hi_cnt    <= 1;
                pend      <= core_lat;
                pend_dout <= core_fn(core_din, core_mode, core_key);
                cap_din   <= core_din;
            end else begin
                if (core_start) hi_cnt <= hi_cnt + 1;
                else if (prev_start) hi_len <= hi_cnt;
                if (pend > 0) begin
                    pend <= pend - 1;
                    if (pend == 1 && core_en) begin
                        core_valid <= 1'b1;
                        core_dout  <= pend_dout;
                    end
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on each handshake
    int mv_cycles = 0;
    always @(negedge clk) begin
        if (!rst && m_valid) mv_cycles++;
        if (!rst && m_valid && m_ready) begin
            chk("sb_nonempty", 64'(exp_data_q.size() != 0), 64'd1);
            if (exp_data_q.size() != 0) begin
                chk("m_data", m_data, exp_data_q.pop_front());
                chk("m_last", 64'(m_last), 64'(exp_last_q.pop_front()));
            end
        end
    end

    task automatic load_iv(input logic [63:0] iv);
        @(negedge clk);
        cfg_iv  = iv;
        iv_load = 1'b1;
        @(posedge clk);
        #1 iv_load = 1'b0;
        mchain = iv;
    endtask

    task automatic send(input logic [63:0] d, input logic last, input logic cbc,
                        input logic dec, input logic push);
        int n = 0;
        logic [63:0] e;
        @(negedge clk);
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_wait", 64'(n < 500), 64'd1);
        cfg_cbc = cbc; cfg_decrypt = dec; s_data = d; s_last = last; s_valid = 1'b1;
        if (!cbc) begin
            e = core_fn(d, dec, cfg_key);
        end else if (!dec) begin
            e = core_fn(d ^ mchain, 1'b0, cfg_key);
            mchain = e;
        end else begin
            e = core_fn(d, 1'b1, cfg_key) ^ mchain;
            mchain = d;
        end
        if (cbc && last) mchain = cfg_iv;
        if (push) begin
            exp_data_q.push_back(e);
            exp_last_q.push_back(last);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy || m_valid || exp_data_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < 500), 64'd1);
    endtask

    initial begin
        int mv0;
        cfg_cbc = 1'b0; cfg_decrypt = 1'b0; cfg_key = KEY; cfg_iv = '0; iv_load = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_core_din", core_din, 64'd0);
        rst = 1'b0;
        #1 chk("s_ready_pre_edge", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1 chk("s_ready_after_rst", 64'(s_ready), 64'd1);

        // ECB encrypt of the known vector
        send(PT, 1'b1, CHAIN_ECB, MODE_ENC, 1'b1);
        wait_idle("ecb_drain");
        chk("ecb_start_len", 64'(hi_len), 64'd2);
        chk("ecb_core_din", cap_din, PT);

        // CBC encrypt: IV folds into the first block, result becomes the chain
        load_iv(PT);
        send(64'd0, 1'b0, CHAIN_CBC, MODE_ENC, 1'b1);
        wait_idle("cbc_enc1_drain");
        chk("cbc_enc_core_din", cap_din, PT);
        send(64'd0, 1'b1, CHAIN_CBC, MODE_ENC, 1'b1);
        wait_idle("cbc_enc2_drain");
        chk("cbc_enc_chain", cap_din, CT);

        // CBC decrypt two-block message, then chain must be back at the IV
        load_iv(PT);
        send(CT, 1'b0, CHAIN_CBC, MODE_DEC, 1'b1);
        send(CT, 1'b1, CHAIN_CBC, MODE_DEC, 1'b1);
        wait_idle("cbc_dec_drain");
        chk("cbc_dec_core_din", cap_din, CT);
        send(64'd0, 1'b1, CHAIN_CBC, MODE_ENC, 1'b1);
        wait_idle("chain_reload_drain");
        chk("chain_reload_din", cap_din, PT);

        // Output backpressure
        @(posedge clk);
        #1 m_ready = 1'b0;
        send(PT, 1'b1, CHAIN_ECB, MODE_ENC, 1'b1);
        begin
            int n = 0;
            @(negedge clk);
            while (!m_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("bp_m_valid_wait", 64'(n < 200), 64'd1);
        end
        repeat (5) begin
            @(negedge clk);
            chk("bp_m_data", m_data, CT);
            chk("bp_m_last", 64'(m_last), 64'd1);
            chk("bp_s_ready", 64'(s_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_s_ready_after", 64'(s_ready), 64'd1);
        chk("bp_m_valid_after", 64'(m_valid), 64'd0);

        // Core timeout
        core_en = 1'b0;
        mv0 = mv_cycles;
        send(PT, 1'b0, CHAIN_ECB, MODE_ENC, 1'b0);
        repeat (63) @(posedge clk);
        #1 chk("tmo_not_yet", 64'(err_timeout), 64'd0);
        @(posedge clk);
        #1 chk("tmo_err", 64'(err_timeout), 64'd1);
        chk("tmo_s_ready", 64'(s_ready), 64'd1);
        chk("tmo_busy", 64'(busy), 64'd0);
        chk("tmo_no_m_valid", 64'(mv_cycles - mv0), 64'd0);
        mchain = cfg_iv;
        core_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("tmo_err_sticky", 64'(err_timeout), 64'd1);
        load_iv(PT);
        chk("tmo_err_cleared", 64'(err_timeout), 64'd0);

        // Reset while waiting on the core
        send(PT, 1'b1, CHAIN_ECB, MODE_ENC, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("mid_rst_core_start", 64'(core_start), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
        chk("mid_rst_core_din", core_din, 64'd0);
        chk("mid_rst_core_key", core_key, 64'd0);
        chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
        exp_data_q.delete();
        exp_last_q.delete();
        mchain = '0;
        @(negedge clk);
        rst = 1'b0;
        send(PT, 1'b1, CHAIN_ECB, MODE_ENC, 1'b1);
        wait_idle("post_rst_drain");

        // Mixed random blocks across modes and keys
        load_iv({$urandom, $urandom});
        for (int i = 0; i < 8; i++) begin
            cfg_key = {$urandom, $urandom};
            send({$urandom, $urandom}, 1'(i == 7), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1);
        end
        wait_idle("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
